// File: rtl/fc_act_packer.sv
// fc_act_packer: post-processing stage behind the FC PE array.
// For each node it adds the node's bias and applies ReLU. The result is
// right-shifted for requantisation and saturated to an unsigned byte.
// PACK results are packed into one output-buffer word per write.
// Pipeline: p1 = bias read issued, p2 = bias returns, p3 = activation ready,
// then the lane merge registers the output-buffer write.
module fc_act_packer #(
    parameter int PSUM_W = 24,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int PACK   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [4:0]               shift_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    output logic                     bias_rden_o,
    output logic [6:0]               bias_rdptr_o,
    input  logic signed [BIAS_W-1:0] bias_rdata_i,
    output logic                     obuf_wren_o,
    output logic [4:0]               obuf_wraddr_o,
    output logic [OUT_W*PACK-1:0]    obuf_wdata_o,
    output logic [PACK-1:0]          obuf_wstrb_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    // PACK is assumed to be a power of two, so the lane is the low index bits
    localparam int LANE_W = $clog2(PACK);
    localparam int WORD_W = OUT_W * PACK;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  shift_q, shift_d;
    logic [6:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        accept;
    logic        start_ok;

    // stage 1: bias read in flight
    logic                     vld_p1_q;
    logic                     last_p1_q;
    logic [6:0]               rdptr_p1_q;
    logic signed [PSUM_W-1:0] psum_p1_q;

    // stage 2: bias data on bias_rdata_i
    logic                     vld_p2_q;
    logic                     last_p2_q;
    logic [6:0]               idx_p2_q;
    logic signed [PSUM_W-1:0] psum_p2_q;

    // stage 3: activation ready for lane merge
    logic                     vld_p3_q;
    logic                     last_p3_q;
    logic [6:0]               idx_p3_q;
    logic [OUT_W-1:0]         act_p3_q;

    // lane accumulator and write port registers
    logic [WORD_W-1:0]        lanes_q;
    logic [PACK-1:0]          strb_q;
    logic [LANE_W-1:0]        lane;
    logic [WORD_W-1:0]        merged_data;
    logic [PACK-1:0]          merged_strb;
    logic                     flush;
    logic                     wren_q;
    logic [4:0]               wraddr_q;
    logic [WORD_W-1:0]        wdata_q;
    logic [PACK-1:0]          wstrb_q;

    // Bias add at PSUM_W+1 bits (cannot overflow), ReLU, then truncating shift
    function automatic logic [PSUM_W:0] relu_shift(
        input logic signed [PSUM_W-1:0] p,
        input logic signed [BIAS_W-1:0] b,
        input logic [4:0]               sh
    );
        logic signed [PSUM_W:0] sum;
        sum = $signed({p[PSUM_W-1], p})
            + $signed({{(PSUM_W + 1 - BIAS_W){b[BIAS_W-1]}}, b});
        if (sum[PSUM_W]) begin
            return '0;
        end
        return $unsigned(sum) >> sh;
    endfunction

    // Clamp a non-negative value to the unsigned activation range
    function automatic logic [OUT_W-1:0] sat_u(input logic [PSUM_W:0] v);
        if (|v[PSUM_W:OUT_W]) begin
            return '1;
        end
        return v[OUT_W-1:0];
    endfunction

    // Layer FSM: next state, node counter, sticky error and done pulse
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        err_d    = err_q;
        done_d   = 1'b0;
        start_ok = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    shift_d  = shift_i;
                    idx_d    = '0;
                    start_ok = 1'b1;
                end
            end
            S_RUN: begin
                if (valid_i) begin
                    accept = 1'b1;
                    idx_d  = idx_q + 7'd1;
                    if (last_i) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // the last node's write is registered this cycle
                if (vld_p3_q && last_p3_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (valid_i && (state_q != S_RUN)) begin
            err_d = 1'b1;
        end
    end

    // FSM and layer control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Stage 1 control: issue bias read for the accepted node
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            last_p1_q  <= 1'b0;
            rdptr_p1_q <= '0;
        end else begin
            vld_p1_q  <= accept;
            last_p1_q <= accept && last_i;
            if (accept) begin
                rdptr_p1_q <= idx_q;
            end
        end
    end

    // Stage 1 data: hold psum while the bias is fetched
    always_ff @(posedge clk) begin
        if (accept) begin
            psum_p1_q <= psum_i;
        end
    end

    // Stage 2/3 control: valid and last follow the node down the pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            vld_p3_q  <= 1'b0;
            last_p3_q <= 1'b0;
        end else begin
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            vld_p3_q  <= vld_p2_q;
            last_p3_q <= last_p2_q;
        end
    end

    // Stage 2/3 data: psum meets its bias, activation computed
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            psum_p2_q <= psum_p1_q;
            idx_p2_q  <= rdptr_p1_q;
        end
        if (vld_p2_q) begin
            act_p3_q <= sat_u(relu_shift(psum_p2_q, bias_rdata_i, shift_q));
            idx_p3_q <= idx_p2_q;
        end
    end

    // Lane merge: drop the activation into its byte lane, decide on a write
    always_comb begin
        lane        = idx_p3_q[LANE_W-1:0];
        merged_data = lanes_q;
        merged_strb = strb_q;
        merged_data[int'(lane)*OUT_W +: OUT_W] = act_p3_q;
        merged_strb[lane] = 1'b1;
        flush = vld_p3_q && ((&lane) || last_p3_q);
    end

    // Lane accumulator and registered output-buffer write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes_q  <= '0;
            strb_q   <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wren_q <= flush;
            if (flush) begin
                wraddr_q <= idx_p3_q[6:LANE_W];
                wdata_q  <= merged_data;
                wstrb_q  <= merged_strb;
                lanes_q  <= '0;
                strb_q   <= '0;
            end else begin
                wraddr_q <= '0;
                wdata_q  <= '0;
                wstrb_q  <= '0;
                if (start_ok) begin
                    lanes_q <= '0;
                    strb_q  <= '0;
                end else if (vld_p3_q) begin
                    lanes_q <= merged_data;
                    strb_q  <= merged_strb;
                end
            end
        end
    end

    assign bias_rden_o   = vld_p1_q;
    assign bias_rdptr_o  = rdptr_p1_q;
    assign obuf_wren_o   = wren_q;
    assign obuf_wraddr_o = wraddr_q;
    assign obuf_wdata_o  = wdata_q;
    assign obuf_wstrb_o  = wstrb_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fc_act_packer.sv
// Testbench for fc_act_packer: per-scenario tasks and a bias RAM model.
// A reference model works from node lists and computes expected words.
module tb_fc_act_packer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_i;
    logic [4:0]         shift_i;
    logic               valid_i;
    logic               last_i;
    logic signed [23:0] psum_i;
    logic               bias_rden_o;
    logic [6:0]         bias_rdptr_o;
    logic signed [15:0] bias_rdata_i = '0;
    logic               obuf_wren_o;
    logic [4:0]         obuf_wraddr_o;
    logic [31:0]        obuf_wdata_o;
    logic [3:0]         obuf_wstrb_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_vcyc = 0;

    int                 psum_arr [0:127];
    logic signed [15:0] bias_mem [0:127];

    int   wr_addr [$];
    int   wr_data [$];
    int   wr_strb [$];
    int   wr_cyc  [$];
    int   rd_addr [$];
    int   done_cyc [$];
    logic done_busy [$];

    fc_act_packer #(
        .PSUM_W(24), .BIAS_W(16), .OUT_W(8), .PACK(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .shift_i(shift_i),
        .valid_i(valid_i), .last_i(last_i), .psum_i(psum_i),
        .bias_rden_o(bias_rden_o), .bias_rdptr_o(bias_rdptr_o),
        .bias_rdata_i(bias_rdata_i), .obuf_wren_o(obuf_wren_o),
        .obuf_wraddr_o(obuf_wraddr_o), .obuf_wdata_o(obuf_wdata_o),
        .obuf_wstrb_o(obuf_wstrb_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bias RAM: one cycle read latency
    always @(posedge clk) if (bias_rden_o) bias_rdata_i <= bias_mem[bias_rdptr_o];

    // observe outputs mid-cycle
    always @(negedge clk) begin
        if (obuf_wren_o) begin
            wr_addr.push_back(int'(obuf_wraddr_o));
            wr_data.push_back(int'(obuf_wdata_o));
            wr_strb.push_back(int'(obuf_wstrb_o));
            wr_cyc.push_back(cyc);
        end
        if (bias_rden_o) rd_addr.push_back(int'(bias_rdptr_o));
        if (done_o) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy_o);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_act(input int p, input int b, input int sh);
        longint s;
        s = longint'(p) + longint'(b);
        if (s < 0) return 8'd0;
        s = s >>> sh;
        if (s > 255) return 8'hFF;
        return 8'(s);
    endfunction

    task automatic clear_obs();
        wr_addr.delete(); wr_data.delete(); wr_strb.delete(); wr_cyc.delete();
        rd_addr.delete(); done_cyc.delete(); done_busy.delete();
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            psum_arr[i] = int'($urandom_range(0, 6000)) - 2000;
            if ($urandom_range(0, 9) == 0) psum_arr[i] = int'($urandom_range(0, 8388607));
            bias_mem[i] = 16'(int'($urandom_range(0, 1000)) - 500);
        end
    endtask

    // Drive one layer of n nodes and compare everything against the model
    task automatic run_layer(input int n, input logic [4:0] sh, input int gap_pct,
                             input bit mid_start);
        int nw;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        clear_obs();
        start_i = 1'b1;
        shift_i = sh;
        @(negedge clk);
        start_i = 1'b0;
        shift_i = 5'($urandom);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", busy_o);
        end
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                valid_i = 1'b0;
                last_i  = 1'($urandom_range(0, 1));
                psum_i  = 24'($urandom);
                @(negedge clk);
            end
            valid_i = 1'b1;
            psum_i  = 24'(psum_arr[i]);
            last_i  = (i == n - 1);
            if (mid_start && i == n / 2) begin
                start_i = 1'b1;
                shift_i = ~sh;
            end
            last_vcyc = cyc;
            @(negedge clk);
            start_i = 1'b0;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        for (int k = 0; k < 40 && done_cyc.size() == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);

        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL done_count got %0d want 1", done_cyc.size());
        end
        checks++;
        if (rd_addr.size() != n) begin
            errors++;
            $display("FAIL bias_read_count got %0d want %0d", rd_addr.size(), n);
        end
        for (int i = 0; i < n && i < rd_addr.size(); i++) begin
            checks++;
            if (rd_addr[i] != i) begin
                errors++;
                $display("FAIL bias_rdptr[%0d] got %0d want %0d", i, rd_addr[i], i);
            end
        end
        nw = (n + 3) / 4;
        checks++;
        if (wr_addr.size() != nw) begin
            errors++;
            $display("FAIL write_count got %0d want %0d", wr_addr.size(), nw);
        end
        for (int w = 0; w < nw && w < wr_addr.size(); w++) begin
            exp_data = '0;
            exp_strb = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < n) begin
                    exp_data[8*j +: 8] = ref_act(psum_arr[4*w+j], int'(bias_mem[4*w+j]), int'(sh));
                    exp_strb[j] = 1'b1;
                end
            end
            checks++;
            if (wr_addr[w] != w) begin
                errors++;
                $display("FAIL wr_addr[%0d] got %0d want %0d", w, wr_addr[w], w);
            end
            checks++;
            if (wr_data[w] != int'(exp_data)) begin
                errors++;
                $display("FAIL wr_data[%0d] got %08h want %08h", w, wr_data[w], exp_data);
            end
            checks++;
            if (wr_strb[w] != int'(exp_strb)) begin
                errors++;
                $display("FAIL wr_strb[%0d] got %0h want %0h", w, wr_strb[w], exp_strb);
            end
            if (gap_pct == 0 && w > 0) begin
                checks++;
                if (wr_cyc[w] - wr_cyc[w-1] != 4) begin
                    errors++;
                    $display("FAIL wr_spacing[%0d] got %0d want 4", w, wr_cyc[w] - wr_cyc[w-1]);
                end
            end
        end
        if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
            checks++;
            if (done_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL done_timing got %0d want %0d", done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
            end
            checks++;
            if (done_busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done got %b want 0", done_busy[0]);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_layer got %b want 0", busy_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [52:0] v;
        v = {bias_rden_o, bias_rdptr_o, obuf_wren_o, obuf_wraddr_o, obuf_wdata_o,
             obuf_wstrb_o, busy_o, done_o, err_o};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s outputs got %h want 0", name, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            psum_arr[i] = i + 1;
            bias_mem[i] = '0;
        end
        run_layer(4, 5'd0, 0, 1'b0);
        checks++;
        if (wr_data.size() < 1 || wr_data[0] != 32'h04030201 || wr_strb[0] != 4'hF || wr_addr[0] != 0) begin
            errors++;
            $display("FAIL basic_word got n=%0d data=%08h want 1 write of 04030201 strb F addr 0",
                     wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 0);
        end
        checks++;
        if (wr_cyc.size() < 1 || wr_cyc[0] != last_vcyc + 4) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d",
                     (wr_cyc.size() > 0) ? wr_cyc[0] : -1, last_vcyc + 4);
        end
    endtask

    task automatic test_boundaries();
        psum_arr[0] = -5;   bias_mem[0] = 16'sd3;
        psum_arr[1] = 1000; bias_mem[1] = 16'sd24;
        run_layer(2, 5'd2, 0, 1'b0);
        checks++;
        if (wr_data.size() < 1 || wr_data[0] != 32'h0000FF00 || wr_strb[0] != 4'h3) begin
            errors++;
            $display("FAIL relu_sat_word got %08h want 0000FF00 strb 3",
                     (wr_data.size() > 0) ? wr_data[0] : 0);
        end
        psum_arr[0] = 32'h7FFFFF; bias_mem[0] = 16'sd0;
        psum_arr[1] = 32'h7FFFFF; bias_mem[1] = 16'sh7FFF;
        run_layer(2, 5'd31, 0, 1'b0);
        checks++;
        if (wr_data.size() < 1 || wr_data[0] != 0) begin
            errors++;
            $display("FAIL shift31_word got %08h want 00000000",
                     (wr_data.size() > 0) ? wr_data[0] : -1);
        end
        psum_arr[0] = 32'h7FFFFF; bias_mem[0] = 16'sh7FFF;
        psum_arr[1] = -8388608;   bias_mem[1] = -16'sd32768;
        psum_arr[2] = 255;        bias_mem[2] = 16'sd0;
        psum_arr[3] = 256;        bias_mem[3] = -16'sd1;
        run_layer(4, 5'd0, 0, 1'b0);
        checks++;
        if (wr_data.size() < 1 || wr_data[0] != 32'hFFFF00FF) begin
            errors++;
            $display("FAIL wide_sum_word got %08h want FFFF00FF",
                     (wr_data.size() > 0) ? wr_data[0] : 0);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(84);
        run_layer(84, 5'($urandom_range(0, 4)), 0, 1'b0);
    endtask

    task automatic test_partial();
        fill_random(10);
        run_layer(10, 5'($urandom_range(0, 4)), 30, 1'b1);
    endtask

    task automatic test_random();
        for (int l = 0; l < 4; l++) begin
            int n;
            n = int'($urandom_range(1, 40));
            fill_random(n);
            run_layer(n, 5'($urandom_range(0, 5)), 20, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        start_i = 1'b1;
        shift_i = 5'd0;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            psum_i  = 24'(i + 7);
            last_i  = 1'b0;
            @(negedge clk);
        end
        valid_i = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_activity got writes=%0d dones=%0d want 0 0",
                     wr_addr.size(), done_cyc.size());
        end
        check_all_zero("after_mid_reset");
        fill_random(4);
        run_layer(4, 5'd1, 0, 1'b0);
    endtask

    task automatic test_err();
        clear_obs();
        valid_i = 1'b1;
        last_i  = 1'b1;
        psum_i  = 24'sd5;
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (rd_addr.size() != 0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL idle_valid_activity got reads=%0d writes=%0d want 0 0",
                     rd_addr.size(), wr_addr.size());
        end
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_err got err=%b busy=%b want 1 0", err_o, busy_o);
        end
        fill_random(6);
        run_layer(6, 5'd2, 10, 1'b0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got %b want 0", err_o);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        shift_i = '0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        psum_i  = '0;
        for (int i = 0; i < 128; i++) begin
            psum_arr[i] = 0;
            bias_mem[i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_partial();
        test_random();
        test_reset_mid();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
